// File: rtl/rf_burst_reader_pkg.sv
// Shared definitions for the burst-read register file.
// Provides the default data/address widths, the storage depth and the
// burst FSM state encoding used by rf_burst_reader and rf_store_32x32.
package rf_burst_reader_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;

    // Number of registers addressable with 'aw' address bits.
    function automatic int rf_depth(input int aw);
        return 1 << aw;
    endfunction

    localparam int RF_DEPTH = rf_depth(RF_ADDR_WIDTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } burst_state_e;

endpackage

// File: rtl/rf_burst_reader_store.sv
// rf_store_32x32: register storage with one synchronous write port and one
// combinational read port. Register 0 is hardwired to zero: writes to it are
// dropped and reads of it return 0. Synchronous active-high reset clears all
// registers.
//
// Ports:
//   clk      - clock, all updates on rising edge
//   rst      - synchronous active-high reset
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - combinational read address
//   rd_data  - combinational read data
module rf_store_32x32
    import rf_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = rf_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Entry 0 is never written after reset, but the explicit zero keeps the
    // read correct even before the first reset.
    assign rd_data = (rd_addr == '0) ? '0 : mem[rd_addr];

endmodule

// File: rtl/rf_burst_reader.sv
// rf_burst_reader: register file with a single-request burst read engine.
// A request accepted in IDLE latches a start address and a beat count
// (RD_LEN, 0 meaning a full 32-beat sweep) and streams one registered beat
// per cycle starting the cycle after acceptance. The address wraps at the
// top of the file. A write landing on the address of the beat being formed
// is forwarded so the beat carries the new value.
//
// Ports:
//   CLK      - clock
//   RST      - synchronous active-high reset
//   WR_EN    - write strobe
//   WR_ADDR  - write address
//   WR_DATA  - write data
//   RD_REQ   - burst request, only honoured while RD_BUSY=0
//   RD_ADDR  - burst start address
//   RD_LEN   - burst length (0 = full depth)
//   RD_BUSY  - burst in progress
//   RD_VALID - RD_DATA holds a beat
//   RD_LAST  - final beat of the burst
//   RD_DATA  - beat data, 0 when RD_VALID=0
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no beat on the outputs; a request here forms the first beat
// ST_BURST | a beat is on the outputs; cnt_q beats remain including it
module rf_burst_reader
    import rf_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR_EN,
    input  logic [ADDR_WIDTH-1:0] WR_ADDR,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  RD_REQ,
    input  logic [ADDR_WIDTH-1:0] RD_ADDR,
    input  logic [ADDR_WIDTH-1:0] RD_LEN,
    output logic                  RD_BUSY,
    output logic                  RD_VALID,
    output logic                  RD_LAST,
    output logic [DATA_WIDTH-1:0] RD_DATA
);

    // One extra bit so the full-depth count is representable.
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]         CNT_FULL = CW'(rf_depth(ADDR_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    burst_state_e          state_q;
    burst_state_e          state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  last_q;

    logic                  beat_fire;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [CW-1:0]         beat_cnt;
    logic                  beat_last;
    logic                  bypass;
    logic [DATA_WIDTH-1:0] beat_data;
    logic [DATA_WIDTH-1:0] store_rd_data;

    rf_store_32x32 #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_store (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (WR_EN),
        .wr_addr (WR_ADDR),
        .wr_data (WR_DATA),
        .rd_addr (beat_addr),
        .rd_data (store_rd_data)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (RD_REQ) begin
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Decide whether a beat is formed at the coming edge, and for which
    // address and remaining count.
    always_comb begin
        beat_fire = 1'b0;
        beat_addr = addr_q + ADDR_ONE;
        beat_cnt  = cnt_q - CNT_ONE;
        case (state_q)
            ST_IDLE: begin
                beat_fire = RD_REQ;
                beat_addr = RD_ADDR;
                beat_cnt  = (RD_LEN == '0) ? CNT_FULL : {1'b0, RD_LEN};
            end
            ST_BURST: begin
                beat_fire = (cnt_q != CNT_ONE);
            end
            default: beat_fire = 1'b0;
        endcase
    end

    // The store only sees this cycle's write after the edge, so forward it.
    assign bypass    = WR_EN && (WR_ADDR != '0) && (WR_ADDR == beat_addr);
    assign beat_data = bypass ? WR_DATA : store_rd_data;
    assign beat_last = (beat_cnt == CNT_ONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= beat_fire;
            last_q  <= beat_fire && beat_last;
            data_q  <= beat_fire ? beat_data : '0;
            if (beat_fire) begin
                addr_q <= beat_addr;
                cnt_q  <= beat_cnt;
            end
        end
    end

    assign RD_BUSY  = (state_q == ST_BURST);
    assign RD_VALID = valid_q;
    assign RD_LAST  = last_q;
    assign RD_DATA  = data_q;

endmodule
